// File: rtl/pcie_trans_vcq.sv
// pcie_trans_vcq: NUM_VC virtual-channel queues with strict/round-robin arbitration onto a registered, destination-tagged output.
module pcie_trans_vcq #(
  parameter int BITNUMBER = 6,
  parameter int NUM_VC = 4,
  parameter int NUM_D = 2,
  parameter int DEPTH = 8,
  parameter int MODE = 0,
  localparam int VCW = $clog2(NUM_VC),
  localparam int DW = $clog2(NUM_D),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [CW-1:0]        umbral_in,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 push,
  input  logic [NUM_D-1:0]     dest_pause,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic [DW-1:0]        dest_out,
  output logic [VCW-1:0]       vc_out,
  output logic [NUM_VC-1:0]    pause_out,
  output logic [NUM_VC-1:0]    vc_empty,
  output logic                 error_out,
  output logic [3:0]           state
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [3:0] {INIT = 4'b0001, IDLE = 4'b0010, ACTIVE = 4'b0100, ERROR = 4'b1000} st_t;
  st_t st;
  logic [BITNUMBER-1:0] mem [NUM_VC][DEPTH];
  logic [BITNUMBER-1:0] head [NUM_VC];
  logic [AW-1:0] rd_ptr [NUM_VC];
  logic [AW-1:0] wr_ptr [NUM_VC];
  logic [CW-1:0] cnt [NUM_VC];
  logic [CW-1:0] umbral_reg;
  logic [VCW-1:0] rr_ptr, gnt, idx, push_vc;
  logic [NUM_VC-1:0] elig, wr_en, pop;
  logic gnt_v, any, ovf, push_ok;
  assign push_vc = data_in[BITNUMBER-1 -: VCW];
  assign state = st;
  always_comb begin
    any = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      head[v] = mem[v][rd_ptr[v]];
      elig[v] = cnt[v] != '0 && !dest_pause[head[v][BITNUMBER-VCW-1 -: DW]] && st != INIT;
      vc_empty[v] = cnt[v] == '0;
      pause_out[v] = umbral_reg == '0 ? cnt[v] == CW'(DEPTH) : cnt[v] >= umbral_reg;
      any = any | (cnt[v] != '0);
    end
  end
  // round-robin search starts just after the last granted VC
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = MODE == 1 ? rr_ptr + VCW'(i + 1) : VCW'(i);
      if (!gnt_v && elig[idx]) begin
        gnt_v = 1'b1;
        gnt = idx;
      end
    end
  end
  // a full VC still accepts a word when it is popped on the same edge
  assign pop = gnt_v ? NUM_VC'(1) << gnt : '0;
  assign push_ok = push && (cnt[push_vc] != CW'(DEPTH) || pop[push_vc]);
  assign ovf = push && !push_ok;
  assign wr_en = push_ok ? NUM_VC'(1) << push_vc : '0;
  always_ff @(posedge clk)
    if (push_ok) mem[push_vc][wr_ptr[push_vc]] <= data_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= INIT;
      umbral_reg <= CW'(DEPTH - 1);
      rr_ptr <= VCW'(NUM_VC - 1);
      data_out <= '0;
      valid_out <= 1'b0;
      dest_out <= '0;
      vc_out <= '0;
      error_out <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        cnt[v] <= '0;
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        cnt[v] <= cnt[v] + CW'(wr_en[v]) - CW'(pop[v]);
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + AW'(1);
        if (pop[v]) rd_ptr[v] <= rd_ptr[v] + AW'(1);
      end
      valid_out <= gnt_v;
      if (gnt_v) begin
        data_out <= head[gnt];
        dest_out <= head[gnt][BITNUMBER-VCW-1 -: DW];
        vc_out <= gnt;
        rr_ptr <= gnt;
      end
      if (st == INIT) umbral_reg <= umbral_in;
      if (ovf) error_out <= 1'b1;
      st <= ovf ? ERROR :
            st == INIT ? (init ? INIT : IDLE) :
            st == IDLE ? (init ? INIT : (any || push) ? ACTIVE : IDLE) :
            st == ACTIVE ? ((any || push) ? ACTIVE : IDLE) : ERROR;
    end
endmodule

// File: tb/tb_pcie_trans_vcq.sv
// tb_pcie_trans_vcq: drives a strict-priority and a round-robin instance with shared stimulus; a queue-level model feeds per-instance scoreboards.
module tb_pcie_trans_vcq;
  logic clk = 1'b0;
  logic reset, init, push;
  logic [3:0] umbral_in;
  logic [5:0] data_in;
  logic [1:0] dest_pause;
  logic [5:0] d0, d1;
  logic v0, v1, ds0, ds1, er0, er1;
  logic [1:0] vc0, vc1;
  logic [3:0] p0, p1, e0, e1, s0, s1;
  int n_cmp = 0, n_bad = 0;
  logic [5:0] mq [2][4][$];
  logic [5:0] exp_q [2][$];
  int mptr [2];
  int mumb [2];
  logic [3:0] mst [2];
  bit merr [2];
  bit mval [2];

  always #5 clk = ~clk;

  pcie_trans_vcq #(.MODE(0)) u0 (.clk(clk), .reset(reset), .init(init), .umbral_in(umbral_in),
    .data_in(data_in), .push(push), .dest_pause(dest_pause), .data_out(d0), .valid_out(v0),
    .dest_out(ds0), .vc_out(vc0), .pause_out(p0), .vc_empty(e0), .error_out(er0), .state(s0));
  pcie_trans_vcq #(.MODE(1)) u1 (.clk(clk), .reset(reset), .init(init), .umbral_in(umbral_in),
    .data_in(data_in), .push(push), .dest_pause(dest_pause), .data_out(d1), .valid_out(v1),
    .dest_out(ds1), .vc_out(vc1), .pause_out(p1), .vc_empty(e1), .error_out(er1), .state(s1));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: per-VC FIFOs, grant picked from the queue heads by mode rule
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        for (int v = 0; v < 4; v++) mq[m][v].delete();
        exp_q[m].delete();
        mptr[m] = 3;
        mumb[m] = 7;
        mst[m] = 4'b0001;
        merr[m] = 1'b0;
        mval[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        bit any, got, ovf;
        int g, v, vc;
        logic [5:0] h;
        any = 1'b0;
        for (int i = 0; i < 4; i++) if (mq[m][i].size() > 0) any = 1'b1;
        got = 1'b0;
        g = 0;
        for (int i = 0; i < 4; i++) begin
          v = m == 1 ? (mptr[m] + 1 + i) % 4 : i;
          if (!got && mst[m] != 4'b0001 && mq[m][v].size() > 0) begin
            h = mq[m][v][0];
            if (!dest_pause[h[3]]) begin
              got = 1'b1;
              g = v;
            end
          end
        end
        if (got) begin
          exp_q[m].push_back(mq[m][g].pop_front());
          mptr[m] = g;
        end
        ovf = 1'b0;
        if (push) begin
          vc = int'(data_in[5:4]);
          if (mq[m][vc].size() < 8) mq[m][vc].push_back(data_in);
          else ovf = 1'b1;
        end
        mval[m] = got;
        if (mst[m] == 4'b0001) mumb[m] = int'(umbral_in);
        if (ovf || mst[m] == 4'b1000) mst[m] = 4'b1000;
        else if (mst[m] == 4'b0001) mst[m] = init ? 4'b0001 : 4'b0010;
        else if (mst[m] == 4'b0010) mst[m] = init ? 4'b0001 : (any || push) ? 4'b0100 : 4'b0010;
        else mst[m] = (any || push) ? 4'b0100 : 4'b0010;
        if (ovf) merr[m] = 1'b1;
      end
    end
  end

  task automatic mon(int m, logic [5:0] d, logic v, logic dst, logic [1:0] vc,
                     logic [3:0] pz, logic [3:0] em, logic er, logic [3:0] s);
    logic [5:0] w;
    logic [3:0] ep, ee;
    chk($sformatf("valid_out[m%0d]", m), 32'(v), 32'(mval[m]));
    if (v && exp_q[m].size() > 0) begin
      w = exp_q[m].pop_front();
      chk($sformatf("data_out[m%0d]", m), 32'(d), 32'(w));
      chk($sformatf("vc_out[m%0d]", m), 32'(vc), 32'(w[5:4]));
      chk($sformatf("dest_out[m%0d]", m), 32'(dst), 32'(w[3]));
    end
    for (int i = 0; i < 4; i++) begin
      ee[i] = mq[m][i].size() == 0;
      ep[i] = mumb[m] == 0 ? mq[m][i].size() == 8 : mq[m][i].size() >= mumb[m];
    end
    chk($sformatf("pause_out[m%0d]", m), 32'(pz), 32'(ep));
    chk($sformatf("vc_empty[m%0d]", m), 32'(em), 32'(ee));
    chk($sformatf("error_out[m%0d]", m), 32'(er), 32'(merr[m]));
    chk($sformatf("state[m%0d]", m), 32'(s), 32'(mst[m]));
  endtask

  always @(negedge clk) begin
    mon(0, d0, v0, ds0, vc0, p0, e0, er0, s0);
    mon(1, d1, v1, ds1, vc1, p1, e1, er1, s1);
  end

  task automatic cyc(bit p, logic [5:0] d, logic [1:0] dp, bit in);
    @(negedge clk);
    push = p;
    data_in = d;
    dest_pause = dp;
    init = in;
  endtask

  task automatic do_reset(logic [3:0] umb);
    @(negedge clk);
    #2;
    reset = 1'b0;
    init = 1'b1;
    push = 1'b0;
    dest_pause = 2'b00;
    umbral_in = umb;
    #1;
    chk("reset valid_out", 32'({v0, v1}), 32'h0);
    chk("reset vc_empty", 32'({e0, e1}), 32'hff);
    chk("reset state", 32'({s0, s1}), 32'h11);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(int n, logic [1:0] dp);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'h0, dp, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    init = 1'b1;
    push = 1'b0;
    data_in = '0;
    dest_pause = '0;
    umbral_in = 4'd3;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // threshold 3 latched in INIT, then VC0 fills behind paused destinations
    repeat (3) cyc(1'b0, 6'h0, 2'b00, 1'b1);
    idle(2, 2'b11);
    for (int i = 0; i < 4; i++) cyc(1'b1, 6'(i), 2'b11, 1'b0);
    idle(10, 2'b00);
    // VC1 then VC0 on consecutive edges
    cyc(1'b1, 6'b01_0001, 2'b00, 1'b0);
    cyc(1'b1, 6'b00_0010, 2'b00, 1'b0);
    idle(5, 2'b00);
    // two words per VC preloaded in INIT, then released together
    do_reset(4'd0);
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 4; v++) cyc(1'b1, {2'(v), 1'($urandom), 3'(r * 4 + v)}, 2'b00, 1'b1);
    idle(12, 2'b00);
    // head destinations 1 (VC0) and 0 (VC1) with destination 1 paused
    cyc(1'b1, 6'b00_1011, 2'b11, 1'b0);
    cyc(1'b1, 6'b01_0100, 2'b11, 1'b0);
    idle(3, 2'b10);
    idle(4, 2'b00);
    // overflow of VC2 then drain
    do_reset(4'd8);
    idle(2, 2'b11);
    for (int i = 0; i < 9; i++) cyc(1'b1, {2'b10, 4'(i)}, 2'b11, 1'b0);
    idle(12, 2'b00);
    // reset with five words queued
    do_reset(4'd5);
    idle(2, 2'b11);
    for (int i = 0; i < 5; i++) cyc(1'b1, 6'($urandom), 2'b11, 1'b0);
    do_reset(4'd4);
    // randomized traffic
    idle(2, 2'b00);
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 1)), 6'($urandom), $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00,
          $urandom_range(0, 199) == 0);
    do_reset(4'($urandom_range(0, 8)));
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 2) != 0), 6'($urandom), 2'($urandom), $urandom_range(0, 299) == 0);
    idle(40, 2'b00);
    chk("leftover expected m0", 32'(exp_q[0].size()), 32'h0);
    chk("leftover expected m1", 32'(exp_q[1].size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
